// File: rtl/if_id_buffer.sv
// ---------------------------------------------------------------------------
// if_id_buffer
//
// Fetch-side buffer sitting between the IF stage and the ID stage.
//
// IF presents a fetch address on inst_addr, which also drives the address
// port of a synchronous instruction ROM. The ROM returns the word one cycle
// later on inst_rdata. This block remembers which address was accepted
// (req_pc/req_v) so that it can pair the returning word with its pc. Each
// pair is then either handed straight to ID or parked in a small FIFO.
//
// ID sees registered {id_pc, id_inst, id_valid}. When nothing real is
// available, id_inst carries a NOP. IF is back-pressured through
// if_stall. A flush (taken jump/branch) squashes everything that is in
// flight or queued.
//
// Parameters
//   DEPTH  FIFO entries (>= 2)
//   NOP    instruction driven on id_inst while id_valid is low
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst_n       asynchronous reset, active low
//   ce          fetch request from IF this cycle
//   inst_addr   fetch address from IF (also the ROM address)
//   inst_rdata  ROM data for the address presented in the previous cycle
//   flush       squash all in-flight and queued fetches
//   id_stall    ID cannot accept; id_* outputs must hold
//   if_stall    combinational back-pressure to IF (hold pc / inst_addr)
//   id_pc       pc of the instruction presented to ID
//   id_inst     instruction presented to ID
//   id_valid    id_pc / id_inst describe a real instruction
// ---------------------------------------------------------------------------
module if_id_buffer #(
    parameter int          DEPTH = 2,
    parameter logic [31:0] NOP   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_rdata,
    input  logic        flush,
    input  logic        id_stall,
    output logic        if_stall,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    // In-flight request: address accepted at the previous edge whose
    // instruction word is on inst_rdata during this cycle.
    logic          req_v;
    logic [31:0]   req_pc;

    // FIFO bookkeeping and storage.
    logic [CW-1:0] count;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];

    logic [CW:0]   occupancy;
    logic          fifo_empty;
    logic          advance;
    logic          pop;
    logic          bypass;
    logic          push;
    logic          accept;

    // Pointer increment that wraps at DEPTH, so non power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Back-pressure is deliberately conservative: it counts the in-flight
    // word as already occupying a slot and ignores a pop happening in the
    // same cycle. That way the word returning next cycle and any newly
    // accepted fetch always have somewhere to go, so the FIFO can never
    // overflow.
    assign occupancy  = {1'b0, count} + {{CW{1'b0}}, req_v};
    assign if_stall   = (occupancy >= DEPTH_W);

    // ID advances whenever it is not stalled. Flush is handled separately
    // and beats everything else.
    assign fifo_empty = (count == '0);
    assign advance    = !flush && !id_stall;
    assign pop        = advance && !fifo_empty;

    // Older queued words always go to ID first. The returning word may skip
    // the FIFO only when the queue is empty.
    assign bypass     = advance && fifo_empty && req_v;
    assign push       = !flush && req_v && !bypass;
    assign accept     = ce && !if_stall && !flush;

    // Track the outstanding ROM read. The address of a flush cycle is the
    // wrong-path address and is dropped; the jump target that IF presents
    // in the following cycle is accepted normally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_v  <= 1'b0;
            req_pc <= '0;
        end else begin
            req_v <= accept;
            if (accept) begin
                req_pc <= inst_addr;
            end
        end
    end

    // FIFO occupancy and pointers. Flush empties the queue by resetting
    // the pointers; the stale storage contents are simply never read again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
        end else if (flush) begin
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
        end else begin
            if (push) begin
                wptr <= ptr_inc(wptr);
            end
            if (pop) begin
                rptr <= ptr_inc(rptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage. No reset: an entry is only read after it has been
    // written, because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wptr]   <= req_pc;
            inst_mem[wptr] <= inst_rdata;
        end
    end

    // Registered ID-side outputs. While ID is stalled they hold. With
    // nothing to deliver, a bubble goes out: the NOP with the pc left
    // unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid <= 1'b0;
            id_inst  <= NOP;
            id_pc    <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
            id_inst  <= NOP;
        end else if (!id_stall) begin
            if (pop) begin
                id_valid <= 1'b1;
                id_pc    <= pc_mem[rptr];
                id_inst  <= inst_mem[rptr];
            end else if (req_v) begin
                id_valid <= 1'b1;
                id_pc    <= req_pc;
                id_inst  <= inst_rdata;
            end else begin
                id_valid <= 1'b0;
                id_inst  <= NOP;
            end
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// ---------------------------------------------------------------------------
// tb_if_id_buffer
//
// Testbench for if_id_buffer with DEPTH=2. It models a synchronous ROM
// (data = addr ^ 32'hA5A5_0000, one cycle late) and an IF stage that holds
// its pc while if_stall is high. The expected ID-side behaviour comes from
// a transaction-level reference model: a queue of accepted pcs waiting to
// reach ID, plus the one fetch whose ROM word is still in flight.
// ---------------------------------------------------------------------------
module tb_if_id_buffer;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        ce;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        flush;
    logic        id_stall;
    logic        if_stall;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;

    int checks;
    int fails;

    // Reference model state.
    logic [31:0] mq[$];
    bit          m_inf_v;
    logic [31:0] m_inf_pc;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    bit          m_valid;
    bit          last_acc;
    logic [31:0] if_pc;

    if_id_buffer #(
        .DEPTH (DEPTH),
        .NOP   (NOP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ce         (ce),
        .inst_addr  (inst_addr),
        .inst_rdata (inst_rdata),
        .flush      (flush),
        .id_stall   (id_stall),
        .if_stall   (if_stall),
        .id_pc      (id_pc),
        .id_inst    (id_inst),
        .id_valid   (id_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Synchronous ROM: the data appears one cycle after the address.
    always @(posedge clk) inst_rdata <= rom(inst_addr);

    // The reference model counts the in-flight fetch as occupying a slot.
    function automatic bit m_stall();
        return (mq.size() + int'(m_inf_v)) >= DEPTH;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_inf_v  = 0;
        m_inf_pc = '0;
        m_pc     = '0;
        m_inst   = NOP;
        m_valid  = 0;
        last_acc = 0;
    endtask

    // Advance one clock edge: update the model with the inputs seen at
    // the edge, move the IF pc on if the fetch was accepted, and return
    // 1 time unit after the edge.
    task automatic tick();
        bit consumed;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            last_acc = ce && !m_stall() && !flush;
            consumed = 0;
            if (flush) begin
                mq.delete();
                m_valid = 0;
                m_inst  = NOP;
            end else begin
                if (!id_stall) begin
                    if (mq.size() > 0) begin
                        m_pc    = mq.pop_front();
                        m_inst  = rom(m_pc);
                        m_valid = 1;
                    end else if (m_inf_v) begin
                        m_pc     = m_inf_pc;
                        m_inst   = rom(m_pc);
                        m_valid  = 1;
                        consumed = 1;
                    end else begin
                        m_valid = 0;
                        m_inst  = NOP;
                    end
                end
                if (m_inf_v && !consumed) mq.push_back(m_inf_pc);
            end
            m_inf_v  = last_acc;
            m_inf_pc = inst_addr;
            if (last_acc) if_pc = if_pc + 32'd4;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; ce = 1'b0; flush = 1'b0; id_stall = 1'b0;
        inst_addr = '0; if_pc = '0;
        #1 rst_n = 1'b0;
        #2;
        model_reset();
        checks++; if (id_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset id_valid: got %0b expected 0", id_valid); end
        checks++; if (id_inst !== NOP) begin fails++; $display("[TB] FAIL reset id_inst: got %h expected %h", id_inst, NOP); end
        checks++; if (id_pc !== 32'h0) begin fails++; $display("[TB] FAIL reset id_pc: got %h expected 0", id_pc); end
        checks++; if (if_stall !== 1'b0) begin fails++; $display("[TB] FAIL reset if_stall: got %0b expected 0", if_stall); end
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        if_pc = 32'h0;
        for (int i = 0; i < 7; i++) begin
            ce = (i < 4); id_stall = 1'b0; flush = 1'b0; inst_addr = if_pc;
            checks++; if (if_stall !== m_stall()) begin fails++; $display("[TB] FAIL stream if_stall cyc %0d: got %0b expected %0b", i, if_stall, m_stall()); end
            tick();
            checks++; if (id_valid !== m_valid || id_pc !== m_pc || id_inst !== m_inst)
                begin fails++; $display("[TB] FAIL stream id cyc %0d: got v=%0b pc=%h inst=%h expected v=%0b pc=%h inst=%h", i, id_valid, id_pc, id_inst, m_valid, m_pc, m_inst); end
            if (i >= 1 && i <= 4) begin
                checks++;
                if (id_valid !== 1'b1 || id_pc !== 32'((i - 1) * 4) || id_inst !== rom(32'((i - 1) * 4)))
                    begin fails++; $display("[TB] FAIL stream latency cyc %0d: got v=%0b pc=%h expected v=1 pc=%h", i, id_valid, id_pc, (i - 1) * 4); end
            end
        end
    endtask

    task automatic test_back_pressure();
        bit saw_stall;
        saw_stall = 0;
        if_pc = 32'h1000;
        for (int i = 0; i < 16; i++) begin
            ce = (i < 12); flush = 1'b0; id_stall = (i >= 3 && i < 7); inst_addr = if_pc;
            if (if_stall === 1'b1) saw_stall = 1;
            checks++; if (if_stall !== m_stall()) begin fails++; $display("[TB] FAIL backpressure if_stall cyc %0d: got %0b expected %0b", i, if_stall, m_stall()); end
            tick();
            checks++; if (id_valid !== m_valid || id_pc !== m_pc || id_inst !== m_inst)
                begin fails++; $display("[TB] FAIL backpressure id cyc %0d: got v=%0b pc=%h expected v=%0b pc=%h", i, id_valid, id_pc, m_valid, m_pc); end
        end
        checks++; if (saw_stall !== 1'b1) begin fails++; $display("[TB] FAIL backpressure if_stall never rose: got 0 expected 1"); end
    endtask

    task automatic test_flush_full();
        logic [31:0] seen[$];
        if_pc = 32'h40;
        for (int i = 0; i < 4; i++) begin
            ce = 1'b1; flush = 1'b0; id_stall = 1'b1; inst_addr = if_pc;
            checks++; if (if_stall !== m_stall()) begin fails++; $display("[TB] FAIL flushfull fill if_stall cyc %0d: got %0b expected %0b", i, if_stall, m_stall()); end
            tick();
        end
        checks++; if (if_stall !== 1'b1) begin fails++; $display("[TB] FAIL flushfull full if_stall: got %0b expected 1", if_stall); end
        flush = 1'b1; id_stall = 1'b0; ce = 1'b1; inst_addr = if_pc;
        tick();
        checks++; if (id_valid !== 1'b0 || id_inst !== NOP)
            begin fails++; $display("[TB] FAIL flushfull bubble: got v=%0b inst=%h expected v=0 inst=%h", id_valid, id_inst, NOP); end
        flush = 1'b0;
        if_pc = 32'h100;
        for (int i = 0; i < 5; i++) begin
            ce = 1'b1; inst_addr = if_pc;
            checks++; if (if_stall !== m_stall()) begin fails++; $display("[TB] FAIL flushfull if_stall cyc %0d: got %0b expected %0b", i, if_stall, m_stall()); end
            tick();
            checks++; if (id_valid !== m_valid || id_pc !== m_pc || id_inst !== m_inst)
                begin fails++; $display("[TB] FAIL flushfull id cyc %0d: got v=%0b pc=%h expected v=%0b pc=%h", i, id_valid, id_pc, m_valid, m_pc); end
            if (id_valid === 1'b1) seen.push_back(id_pc);
        end
        checks++; if (seen.size() < 2 || seen[0] !== 32'h100 || seen[1] !== 32'h104)
            begin fails++; $display("[TB] FAIL flushfull target order: got n=%0d first=%h expected 100 then 104", seen.size(), (seen.size() > 0) ? seen[0] : 32'hx); end
        ce = 1'b0;
    endtask

    task automatic test_flush_stall();
        if_pc = 32'h80;
        for (int i = 0; i < 3; i++) begin
            ce = 1'b1; flush = 1'b0; id_stall = 1'b1; inst_addr = if_pc;
            tick();
        end
        flush = 1'b1; id_stall = 1'b1; inst_addr = if_pc;
        tick();
        checks++; if (id_valid !== 1'b0 || id_inst !== NOP)
            begin fails++; $display("[TB] FAIL flushstall bubble: got v=%0b inst=%h expected v=0 inst=%h", id_valid, id_inst, NOP); end
        flush = 1'b0; id_stall = 1'b0;
        if_pc = 32'h200;
        for (int i = 0; i < 6; i++) begin
            ce = 1'b1; inst_addr = if_pc;
            tick();
            checks++; if (id_valid === 1'b1 && id_pc < 32'h200)
                begin fails++; $display("[TB] FAIL flushstall wrong path cyc %0d: got pc=%h expected >= 200", i, id_pc); end
            checks++; if (id_valid !== m_valid || id_pc !== m_pc || id_inst !== m_inst)
                begin fails++; $display("[TB] FAIL flushstall id cyc %0d: got v=%0b pc=%h expected v=%0b pc=%h", i, id_valid, id_pc, m_valid, m_pc); end
        end
        ce = 1'b0;
    endtask

    task automatic test_reset_mid();
        if_pc = 32'h300;
        for (int i = 0; i < 3; i++) begin
            ce = 1'b1; flush = 1'b0; id_stall = 1'b1; inst_addr = if_pc;
            tick();
        end
        checks++; if (if_stall !== 1'b1) begin fails++; $display("[TB] FAIL resetmid full if_stall: got %0b expected 1", if_stall); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (id_valid !== 1'b0 || id_inst !== NOP || id_pc !== 32'h0 || if_stall !== 1'b0)
            begin fails++; $display("[TB] FAIL resetmid async clear: got v=%0b inst=%h pc=%h stall=%0b expected v=0 inst=%h pc=0 stall=0", id_valid, id_inst, id_pc, if_stall, NOP); end
        tick();
        rst_n = 1'b1; id_stall = 1'b0;
        if_pc = 32'h0;
        for (int i = 0; i < 4; i++) begin
            ce = 1'b1; inst_addr = if_pc;
            tick();
            checks++; if (id_valid !== m_valid || id_pc !== m_pc || id_inst !== m_inst)
                begin fails++; $display("[TB] FAIL resetmid id cyc %0d: got v=%0b pc=%h expected v=%0b pc=%h", i, id_valid, id_pc, m_valid, m_pc); end
            if (i == 1) begin
                checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0)
                    begin fails++; $display("[TB] FAIL resetmid restart pc: got v=%0b pc=%h expected v=1 pc=0", id_valid, id_pc); end
            end
        end
        ce = 1'b0;
    endtask

    task automatic test_random();
        bit was_flush;
        was_flush = 0;
        for (int i = 0; i < 500; i++) begin
            if (was_flush) if_pc = {$urandom_range(0, 16'hFFFF), 2'b00};
            ce       = ($urandom_range(0, 3) != 0);
            id_stall = ($urandom_range(0, 2) == 0);
            flush    = ($urandom_range(0, 15) == 0);
            inst_addr = if_pc;
            checks++; if (if_stall !== m_stall()) begin fails++; $display("[TB] FAIL random if_stall cyc %0d: got %0b expected %0b", i, if_stall, m_stall()); end
            checks++; if (dut.push === 1'b1 && dut.count === 2'(DEPTH))
                begin fails++; $display("[TB] FAIL random overflow cyc %0d: got push at count %0d expected no push when full", i, dut.count); end
            was_flush = flush;
            tick();
            checks++; if (id_valid !== m_valid || id_pc !== m_pc || id_inst !== m_inst)
                begin fails++; $display("[TB] FAIL random id cyc %0d: got v=%0b pc=%h inst=%h expected v=%0b pc=%h inst=%h", i, id_valid, id_pc, id_inst, m_valid, m_pc, m_inst); end
        end
        ce = 1'b0; flush = 1'b0; id_stall = 1'b0;
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_stream();
        test_back_pressure();
        test_flush_full();
        test_flush_stall();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
